// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - radix-4 Booth signed multiplier with Dadda reduction and registered result
// Combinational Booth/Dadda datapath captured into a single result register every cycle.
module booth_multiplier #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [2*N:0] result
);

  localparam int W    = 2 * N + 1;
  localparam int M    = N / 2;
  localparam int HMAX = M + 4;
  localparam int NSTG = 8;
  localparam int DSEQ [NSTG] = '{2, 3, 4, 6, 9, 13, 19, 28};

  // Sign-extension compensation: each partial-product sign s is replaced by ~s
  // at its sign weight, and the resulting -2^k offsets are folded into one constant.
  function automatic logic [W-1:0] comp_const();
    logic [W-1:0] k;
    k = '0;
    for (int i = 0; i < M; i++) begin
      k = k + (W'(1) << (N + 2 * i));
    end
    return ~k + W'(1);
  endfunction

  localparam logic [W-1:0] K = comp_const();

  logic [N:0]   bx;
  logic [W-1:0] row0;
  logic [W-1:0] row1;
  logic [W-1:0] result_d;
  logic [W-1:0] result_q;

  assign bx = {B, 1'b0};

  always_comb begin : dadda
    logic [HMAX-1:0] col  [W];
    logic [HMAX-1:0] ncol [W];
    int              ht   [W];
    int              nht  [W];
    logic [2:0]      dig;
    logic            one;
    logic            two;
    logic            neg;
    logic [N:0]      mag;
    logic [N:0]      pp;
    logic            fa_a;
    logic            fa_b;
    logic            fa_c;
    logic            s_bit;
    logic            c_bit;
    int              take;
    int              cur;

    dig   = '0;
    one   = 1'b0;
    two   = 1'b0;
    neg   = 1'b0;
    mag   = '0;
    pp    = '0;
    fa_a  = 1'b0;
    fa_b  = 1'b0;
    fa_c  = 1'b0;
    s_bit = 1'b0;
    c_bit = 1'b0;
    take  = 0;
    cur   = 0;
    for (int c = 0; c < W; c++) begin
      col[c]  = '0;
      ncol[c] = '0;
      ht[c]   = 0;
      nht[c]  = 0;
    end

    for (int i = 0; i < M; i++) begin
      dig = bx[2*i +: 3];
      one = dig[1] ^ dig[0];
      two = (dig[2] & ~dig[1] & ~dig[0]) | (~dig[2] & dig[1] & dig[0]);
      neg = dig[2] & ~(dig[1] & dig[0]);
      mag = one ? {A[N-1], A} : (two ? {A, 1'b0} : '0);
      pp  = mag ^ {(N + 1){neg}};
      for (int j = 0; j < N; j++) begin
        col[2*i+j][ht[2*i+j]] = pp[j];
        ht[2*i+j]++;
      end
      col[2*i+N][ht[2*i+N]] = ~pp[N];
      ht[2*i+N]++;
      col[2*i][ht[2*i]] = neg;
      ht[2*i]++;
    end

    for (int c = 0; c < W; c++) begin
      if (K[c]) begin
        col[c][ht[c]] = 1'b1;
        ht[c]++;
      end
    end

    // Stages above the tallest column only copy bits through.
    for (int s = NSTG - 1; s >= 0; s--) begin
      for (int c = 0; c < W; c++) begin
        ncol[c] = '0;
        nht[c]  = 0;
      end
      for (int c = 0; c < W; c++) begin
        take = 0;
        cur  = ht[c] + nht[c];
        for (int r = 0; r < HMAX; r++) begin
          if (cur > DSEQ[s]) begin
            fa_a = col[c][take];
            fa_b = col[c][take+1];
            if (cur - DSEQ[s] == 1) begin
              s_bit = fa_a ^ fa_b;
              c_bit = fa_a & fa_b;
              take  = take + 2;
              cur   = cur - 1;
            end else begin
              fa_c  = col[c][take+2];
              s_bit = fa_a ^ fa_b ^ fa_c;
              c_bit = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
              take  = take + 3;
              cur   = cur - 2;
            end
            ncol[c][nht[c]] = s_bit;
            nht[c]++;
            if (c + 1 < W) begin
              ncol[c+1][nht[c+1]] = c_bit;
              nht[c+1]++;
            end
          end
        end
        for (int r = 0; r < HMAX; r++) begin
          if (r >= take && r < ht[c]) begin
            ncol[c][nht[c]] = col[c][r];
            nht[c]++;
          end
        end
      end
      for (int c = 0; c < W; c++) begin
        col[c] = ncol[c];
        ht[c]  = nht[c];
      end
    end

    for (int c = 0; c < W; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
  end

  // Carries out of the top column are discarded; the product always fits in W bits.
  always_comb begin
    result_d = row0 + row1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier
// Directed vectors at N=10 plus randomized comparisons at N=4, 10 and 16.
module tb_booth_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  a10, b10;
  logic [20:0] r10;
  logic [3:0]  a4, b4;
  logic [8:0]  r4;
  logic [15:0] a16, b16;
  logic [32:0] r16;

  int checks   = 0;
  int failures = 0;

  booth_multiplier #(.N(10)) dut (.clk(clk), .rst_n(rst_n), .A(a10), .B(b10), .result(r10));
  booth_multiplier #(.N(4))  dut4 (.clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .result(r4));
  booth_multiplier #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .result(r16));

  task automatic test_reset();
    rst_n = 1'b0;
    a10 = 10'h155; b10 = 10'h0AA;
    a4 = 4'h7; b4 = 4'h9;
    a16 = 16'h8000; b16 = 16'h7FFF;
    #1;
    checks++;
    if (r10 !== 21'h0 || r4 !== 9'h0 || r16 !== 33'h0) begin
      failures++;
      $display("FAIL reset_initial r10=%h r4=%h r16=%h required 0", r10, r4, r16);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (r10 !== 21'h0 || r4 !== 9'h0 || r16 !== 33'h0) begin
        failures++;
        $display("FAIL reset_held cycle=%0d r10=%h r4=%h r16=%h required 0", i, r10, r4, r16);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (r10 !== 21'h0) begin
      failures++;
      $display("FAIL reset_release_before_edge r10=%h required 0", r10);
    end
    @(posedge clk); #1;
    checks++;
    if (r10 !== 21'h00E272) begin
      failures++;
      $display("FAIL reset_first_edge r10=%h required 00e272", r10);
    end
  endtask

  task automatic test_trivial();
    logic [9:0]  va [4] = '{10'h000, 10'h001, 10'h3FF, 10'h000};
    logic [9:0]  vb [4] = '{10'h000, 10'h001, 10'h3FF, 10'h2A5};
    logic [20:0] ve [4] = '{21'h0, 21'h1, 21'h1, 21'h0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a10 = va[i]; b10 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (r10 !== ve[i]) begin
        failures++;
        $display("FAIL trivial[%0d] A=%h B=%h result=%h required %h", i, va[i], vb[i], r10, ve[i]);
      end
    end
  endtask

  task automatic test_midrange();
    logic [9:0]  va [3] = '{10'h03F, 10'h03F, 10'h3FE};
    logic [9:0]  vb [3] = '{10'h03F, 10'h3FF, 10'h003};
    logic [20:0] ve [3] = '{21'h000F81, 21'h1FFFC1, 21'h1FFFFA};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a10 = va[i]; b10 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (r10 !== ve[i]) begin
        failures++;
        $display("FAIL midrange[%0d] A=%h B=%h result=%h required %h", i, va[i], vb[i], r10, ve[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [9:0]  va [5] = '{10'h200, 10'h200, 10'h1FF, 10'h200, 10'h1FF};
    logic [9:0]  vb [5] = '{10'h200, 10'h1FF, 10'h1FF, 10'h001, 10'h200};
    logic [20:0] ve [5] = '{21'h040000, 21'h1C0200, 21'h03FC01, 21'h1FFE00, 21'h1C0200};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a10 = va[i]; b10 = vb[i];
      @(posedge clk); #1;
      checks++;
      if (r10 !== ve[i] || r10[20] !== r10[19]) begin
        failures++;
        $display("FAIL extremes[%0d] A=%h B=%h result=%h required %h", i, va[i], vb[i], r10, ve[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a10 = 10'h005; b10 = 10'h007;
    @(posedge clk); #2;
    a10 = 10'h1FF; b10 = 10'h1FF;
    #1;
    checks++;
    if (r10 !== 21'h000023) begin
      failures++;
      $display("FAIL hold_midcycle result=%h required 000023", r10);
    end
    @(posedge clk); #1;
    checks++;
    if (r10 !== 21'h03FC01) begin
      failures++;
      $display("FAIL hold_next_edge result=%h required 03fc01", r10);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    a10 = 10'h03F; b10 = 10'h03F;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (r10 !== 21'h0) begin
      failures++;
      $display("FAIL reset_midstream_async result=%h required 0", r10);
    end
    a10 = 10'h3FE; b10 = 10'h003;
    @(posedge clk); #1;
    checks++;
    if (r10 !== 21'h0) begin
      failures++;
      $display("FAIL reset_midstream_held result=%h required 0", r10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (r10 !== 21'h1FFFFA) begin
      failures++;
      $display("FAIL reset_midstream_release result=%h required 1ffffa", r10);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [20:0] e10;
    logic signed [8:0]  e4;
    logic signed [32:0] e16;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a10 = 10'($urandom);
      b10 = (i % 8 == 3) ? a10 : 10'($urandom);
      if (i % 97 == 5) a10 = 10'h200;
      a4  = 4'($urandom);
      b4  = (i % 8 == 5) ? a4 : 4'($urandom);
      a16 = 16'($urandom);
      b16 = (i % 8 == 1) ? a16 : 16'($urandom);
      if (i % 89 == 7) begin a16 = 16'h8000; b16 = 16'h8000; end
      e10 = $signed(a10) * $signed(b10);
      e4  = $signed(a4) * $signed(b4);
      e16 = $signed(a16) * $signed(b16);
      @(posedge clk); #1;
      checks++;
      if (r10 !== e10 || r4 !== e4 || r16 !== e16) begin
        failures++;
        $display("FAIL random[%0d] r10=%h/%h r4=%h/%h r16=%h/%h (got/required)",
                 i, r10, e10, r4, e4, r16, e16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trivial();
    test_midrange();
    test_extremes();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
